serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial add/subtract unit: it accepts two WIDTH-bit operands through a valid/ready handshake and pushes one bit pair per clock, LSB first, through a single 1-bit `fullAdder` stage. The carry-out of that stage is registered and fed back as the next carry-in. It sits directly upstream of the `fullAdder` cell, sequencing its inputs and collecting its outputs. It gives the datapath a minimum-area alternative to the parallel adder, for use by multi-cycle ALU operations.

## Interface
- `WIDTH`, default 64: operand and result width; must be ≥ 2.
- `clk_i` input 1: clock; all state changes on its rising edge.
- `reset_n_i` input 1: synchronous, active-low reset, sampled on the rising edge of `clk_i`.
- `in_valid_i` input 1: operands and `sub_i` are valid.
- `in_ready_o` output 1: block can accept a new operation.
- `A_i` input WIDTH: operand A.
- `B_i` input WIDTH: operand B.
- `sub_i` input 1: 0 computes A+B; 1 computes A−B.
- `out_valid_o` output 1: `result_o` and the flags are valid.
- `out_ready_i` input 1: consumer accepts the result.
- `result_o` output WIDTH: sum or difference, modulo 2^WIDTH.
- `flags_o` output 4: {N, Z, C, V}. Present only when the macro in Configuration is defined.

## Operation
- Datapath:
  - Shift registers `a_sh` and `b_sh` hold the operands. On accept, `b_sh` loads `B_i ^ {WIDTH{sub_i}}`.
  - Carry register `c_q` loads `sub_i` on accept.
  - Each RUN cycle feeds `a_sh[0]`, `b_sh[0]`, `c_q` into the `fullAdder` instance.
  - `sum_o` shifts into the result register from the MSB end, so after WIDTH shifts bit 0 is the first sum bit.
  - `co_o` is registered into `c_q`.
  - Both operand registers shift right by one.
- Bit counter: $clog2(WIDTH) bits, cleared on accept, incremented in RUN.
- State machine:
  - IDLE: `in_ready_o`=1. On `in_valid_i`=1, load operands and go to RUN.
  - RUN: one bit per cycle. When counter = WIDTH−1, the edge performs the final bit and moves to DONE.
  - DONE: `out_valid_o`=1; `result_o` and flags held stable. On `out_ready_i`=1, go to IDLE.
- No new operation is accepted outside IDLE; `in_ready_o`=0 in RUN and DONE.
- Inputs (`A_i`, `B_i`, `sub_i`) are sampled only on the accept edge. Later changes have no effect.
- Flags, captured on the final RUN edge:
  - N = result[WIDTH−1].
  - Z = (result == 0).
  - C = final carry-out. For subtraction this is the ARM-style "no borrow" flag.
  - V = carry into MSB XOR carry out of MSB. The carry into the MSB is `c_q` before the final bit.
- Reset (`reset_n_i`=0 at an edge), including mid-RUN or in DONE:
  - State goes to IDLE; the operation is abandoned and no result is produced.
  - All registers clear: `out_valid_o`=0, `in_ready_o`=1, `result_o`=0, `flags_o`=0, counter=0, `c_q`=0.

## Timing
- Accept edge: the edge where `in_valid_i`&`in_ready_o`=1 (call it edge 0).
- RUN: edges 1..WIDTH each process one bit.
- `out_valid_o` rises after edge WIDTH. Latency from accept to result = WIDTH cycles.
- If `out_ready_i` is already 1 when `out_valid_o` rises, DONE lasts exactly one cycle.
- Minimum throughput: one operation per WIDTH+2 cycles (accept, WIDTH RUN, DONE). No accept while in DONE.
- Fulladder gate delays (15 ns worst case through the XOR/AND-OR paths) must settle within one period. The bench clock period is ≥ 40 ns.
- `result_o` holds the last result after returning to IDLE, until the next accept. `out_valid_o`=0 there.

## Configuration
- `SERIAL_ADDER_FLAGS_EN` defined:
  - `flags_o` port is present.
  - N/Z/C/V registers are built and captured as in Operation.
- Not defined:
  - `flags_o` port and flag registers are omitted.
  - The V-tracking logic (previous carry) is removed.
  - Result and handshake timing are identical.

## Test plan
- Reset then idle, WIDTH=64 → `in_ready_o`=1, `out_valid_o`=0, `result_o`=0.
- Add 5 + 3, out_ready_i held 1 → `out_valid_o` high exactly 64 cycles after accept for one cycle; `result_o`=8; flags {0,0,0,0}.
- Subtract 3 − 5 → `result_o`=0xFFFF_FFFF_FFFF_FFFE; N=1, Z=0, C=0, V=0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 1 → `result_o`=0x8000_0000_0000_0000; N=1, V=1, C=0. Then add 0xFFFF_FFFF_FFFF_FFFF + 1 → result 0, Z=1, C=1, V=0.
- Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE while toggling `A_i`/`in_valid_i` → result and flags stable, `in_ready_o`=0, no new accept. Release → IDLE next cycle.
- Assert `reset_n_i`=0 for one edge at bit 30 of a RUN → IDLE and all outputs zero next cycle. A fresh 1 + 1 then completes with `result_o`=2.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit driving a single 1-bit full adder (optional flags: SERIAL_ADDER_FLAGS_EN)

module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic co_o
);
    assign sum_o = a_i ^ b_i ^ c_i;
    assign co_o  = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
`ifdef SERIAL_ADDER_FLAGS_EN
    ,
    output logic [3:0]       flags_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c_q;
    logic               w_sum;
    logic               w_co;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_result_nxt;

    assign w_accept     = (r_state == S_IDLE) && in_valid_i;
    assign w_last       = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_result_nxt = {w_sum, r_result[WIDTH-1:1]};

    fullAdder u_fa (
        .a_i   (r_a_sh[0]),
        .b_i   (r_b_sh[0]),
        .c_i   (r_c_q),
        .sum_o (w_sum),
        .co_o  (w_co)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH bit cycles in RUN, hold in DONE until consumed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)      w_state_nxt = S_DONE;
            S_DONE:  if (out_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept (B inverted and carry-in set for subtract), then shift one bit per RUN cycle
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_c_q    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= A_i;
            r_b_sh   <= B_i ^ {WIDTH{sub_i}};
            r_c_q    <= sub_i;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_c_q    <= w_co;
            r_result <= w_result_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_FLAGS_EN
    logic [3:0] r_flags;

    // Flags captured on the final bit; r_c_q still holds the carry into the MSB at that edge
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_flags <= 4'b0000;
        end else if (w_last) begin
            r_flags <= {w_sum, (w_result_nxt == '0), w_co, (r_c_q ^ w_co)};
        end
    end

    assign flags_o = r_flags;
`endif

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign result_o    = r_result;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder with a randomized arithmetic reference model

module tb_serial_adder;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .A_i         (a_in),
        .B_i         (b_in),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
`ifdef SERIAL_ADDER_FLAGS_EN
        ,
        .flags_o     (flags)
`endif
    );

`ifndef SERIAL_ADDER_FLAGS_EN
    assign flags = 4'b0000;
`endif

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: plain wide arithmetic, flags from sign rules of two's-complement add/sub
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] res, output logic [3:0] flg);
        logic [64:0] wide;
        logic n, z, c, v;
        if (s) wide = {1'b0, a} + {1'b0, ~b} + 65'd1;
        else   wide = {1'b0, a} + {1'b0, b};
        res = wide[63:0];
        c   = wide[64];
        n   = res[63];
        z   = (res == 64'd0);
        if (s) v = (a[63] != b[63]) && (res[63] != a[63]);
        else   v = (a[63] == b[63]) && (res[63] != a[63]);
        flg = {n, z, c, v};
    endtask

    // Drives one operation; returns result/flags at first out_valid, latency from accept and accept cycle
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic ordy,
                          output logic [63:0] res, output logic [3:0] flg,
                          output int lat, output int acc_cyc, output bit tmo);
        bit accepted;
        bit was_ready;
        tmo       = 1'b0;
        lat       = -1;
        acc_cyc   = -1;
        accepted  = 1'b0;
        out_ready = ordy;
        a_in      = a;
        b_in      = b;
        sub       = s;
        in_valid  = 1'b1;
        for (int k = 0; k < 200 && !accepted; k++) begin
            was_ready = in_ready;
            @(posedge clk);
            if (was_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            #1;
        end
        in_valid = 1'b0;
        a_in     = rand64();
        b_in     = rand64();
        sub      = ~s;
        if (!accepted) begin
            tmo = 1'b1;
        end else begin
            for (int k = 1; k <= WIDTH + 20; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
            if (lat < 0) tmo = 1'b1;
        end
        res = result;
        flg = flags;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
`ifdef SERIAL_ADDER_FLAGS_EN
        checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [63:0] ta [5] = '{64'd5, 64'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [63:0] tb [5] = '{64'd3, 64'd5, 64'd1, 64'd1, 64'd0};
        logic        ts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] exp_r [5] = '{64'd8, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        logic [3:0]  exp_f [5] = '{4'b0000, 4'b1000, 4'b1001, 4'b0110, 4'b0110};
        logic [63:0] r;
        logic [3:0]  f;
        int lat, acc;
        bit tmo;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], 1'b1, r, f, lat, acc, tmo);
            checks++; if (tmo) begin failures++; $display("FAIL dir%0d_timeout got=timeout exp=result", i); end
            checks++; if (lat != WIDTH) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, WIDTH); end
            checks++; if (r !== exp_r[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, exp_r[i]); end
`ifdef SERIAL_ADDER_FLAGS_EN
            checks++; if (f !== exp_f[i]) begin failures++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, exp_f[i]); end
`endif
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++; $display("FAIL dir%0d_done_one_cycle got=valid%0b/ready%0b exp=valid0/ready1", i, out_valid, in_ready);
            end
            checks++; if (result !== exp_r[i]) begin failures++; $display("FAIL dir%0d_hold_idle got=%h exp=%h", i, result, exp_r[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, er;
        logic [3:0]  f, ef;
        logic        s;
        int lat, acc;
        bit tmo;
        for (int i = 0; i < 20; i++) begin
            a = rand64();
            b = (i % 4 == 0) ? a : rand64();
            s = $urandom_range(0, 1);
            model(a, b, s, er, ef);
            run_op(a, b, s, 1'b1, r, f, lat, acc, tmo);
            checks++; if (tmo || r !== er) begin
                failures++; $display("FAIL rand%0d_result got=%h exp=%h (a=%h b=%h sub=%0b)", i, r, er, a, b, s);
            end
`ifdef SERIAL_ADDER_FLAGS_EN
            checks++; if (f !== ef) begin failures++; $display("FAIL rand%0d_flags got=%b exp=%b", i, f, ef); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, r, er;
        logic [3:0]  f, ef;
        int lat, acc, prev_acc;
        bit tmo;
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            a = rand64();
            b = rand64();
            model(a, b, 1'b0, er, ef);
            run_op(a, b, 1'b0, 1'b1, r, f, lat, acc, tmo);
            checks++; if (tmo || r !== er) begin failures++; $display("FAIL b2b%0d_result got=%h exp=%h", i, r, er); end
            if (prev_acc >= 0) begin
                checks++; if (acc - prev_acc != WIDTH + 2) begin
                    failures++; $display("FAIL b2b%0d_spacing got=%0d exp=%0d", i, acc - prev_acc, WIDTH + 2);
                end
            end
            prev_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, r, er;
        logic [3:0]  f, ef;
        int lat, acc;
        bit tmo;
        a = rand64();
        b = rand64();
        model(a, b, 1'b1, er, ef);
        run_op(a, b, 1'b1, 1'b0, r, f, lat, acc, tmo);
        checks++; if (tmo || r !== er) begin failures++; $display("FAIL bp_result got=%h exp=%h", r, er); end
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            a_in     = rand64();
            b_in     = rand64();
            sub      = ~sub;
            @(posedge clk);
            #1;
            checks++; if (result !== er || flags !== f || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d got=%h/%b v%0b r%0b exp=%h/%b v1 r0", k, result, flags, out_valid, in_ready, er, f);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=v%0b r%0b exp=v0 r1", out_valid, in_ready);
        end
        checks++; if (result !== er) begin failures++; $display("FAIL bp_release_result got=%h exp=%h", result, er); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] r;
        logic [3:0]  f;
        int lat, acc;
        bit tmo, seen;
        out_ready = 1'b1;
        a_in      = rand64();
        b_in      = rand64();
        sub       = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_handshake got=r%0b v%0b exp=r1 v0", in_ready, out_valid);
        end
        checks++; if (result !== 64'd0 || flags !== 4'b0000) begin
            failures++; $display("FAIL midrst_outputs got=%h/%b exp=0/0000", result, flags);
        end
        seen = 1'b0;
        for (int k = 0; k < WIDTH + 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_no_result got=valid exp=none"); end
        run_op(64'd1, 64'd1, 1'b0, 1'b1, r, f, lat, acc, tmo);
        checks++; if (tmo || r !== 64'd2) begin failures++; $display("FAIL midrst_fresh got=%h exp=2", r); end
`ifdef SERIAL_ADDER_FLAGS_EN
        checks++; if (f !== 4'b0000) begin failures++; $display("FAIL midrst_fresh_flags got=%b exp=0000", f); end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
